// File: rtl/ridecore_inst_pkg.sv
// Shared constants for the random RV32 instruction generator.
// INST_GEN_MUL_EN widens the R-ALU op table to include the M-extension multiplies.
package ridecore_inst_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_NOP   = 7'b1111111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_MUL     = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_WORD   = 3'b010;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_INIT = 32'h0000_0001;
  localparam logic [31:0] NOP_WORD  = 32'h0000_007F;

`ifdef INST_GEN_MUL_EN
  localparam logic [3:0] N_R = 4'd14;
`else
  localparam logic [3:0] N_R = 4'd10;
`endif
  localparam logic [3:0] N_I = 4'd9;

  // Galois form, shifting right: feedback bit is the one shifted out.
  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/inst_encode.sv
// Combinational map from LFSR state to one allowed RV32 instruction word.
// Multiply ops appear only when INST_GEN_MUL_EN is defined.
module inst_encode
  import ridecore_inst_pkg::*;
(
  input  logic [31:0] i_lfsr,
  output logic [31:0] o_instr
);

  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [3:0]  w_r_idx, w_i_idx;
  logic [2:0]  w_r_f3, w_i_f3;
  logic [6:0]  w_r_f7;
  logic [11:0] w_i_imm, w_mem_imm;

  // Register numbers keep bit 4 clear so only x0..x15 are used.
  assign w_rd      = {1'b0, i_lfsr[10:7]};
  assign w_rs1     = {1'b0, i_lfsr[14:11]};
  assign w_rs2     = {1'b0, i_lfsr[18:15]};
  assign w_mem_imm = {2'b00, i_lfsr[28:19]};
  assign w_r_idx   = (i_lfsr[6:3] >= N_R) ? i_lfsr[6:3] - N_R : i_lfsr[6:3];
  assign w_i_idx   = (i_lfsr[6:3] >= N_I) ? i_lfsr[6:3] - N_I : i_lfsr[6:3];

  always_comb begin
    w_r_f3 = F3_ADD_SUB;
    w_r_f7 = F7_BASE;
    case (w_r_idx)
      4'd0:  w_r_f3 = F3_ADD_SUB;
      4'd1:  begin w_r_f3 = F3_ADD_SUB; w_r_f7 = F7_ALT; end
      4'd2:  w_r_f3 = F3_SLL;
      4'd3:  w_r_f3 = F3_SLT;
      4'd4:  w_r_f3 = F3_SLTU;
      4'd5:  w_r_f3 = F3_XOR;
      4'd6:  w_r_f3 = F3_SRL_SRA;
      4'd7:  begin w_r_f3 = F3_SRL_SRA; w_r_f7 = F7_ALT; end
      4'd8:  w_r_f3 = F3_OR;
      4'd9:  w_r_f3 = F3_AND;
`ifdef INST_GEN_MUL_EN
      4'd10: begin w_r_f3 = F3_MUL;    w_r_f7 = F7_MULDIV; end
      4'd11: begin w_r_f3 = F3_MULH;   w_r_f7 = F7_MULDIV; end
      4'd12: begin w_r_f3 = F3_MULHSU; w_r_f7 = F7_MULDIV; end
      4'd13: begin w_r_f3 = F3_MULHU;  w_r_f7 = F7_MULDIV; end
`endif
      default: begin w_r_f3 = F3_ADD_SUB; w_r_f7 = F7_BASE; end
    endcase
  end

  always_comb begin
    w_i_f3  = F3_ADD_SUB;
    w_i_imm = i_lfsr[30:19];
    case (w_i_idx)
      4'd0: w_i_f3 = F3_ADD_SUB;
      4'd1: w_i_f3 = F3_SLT;
      4'd2: w_i_f3 = F3_SLTU;
      4'd3: w_i_f3 = F3_XOR;
      4'd4: w_i_f3 = F3_OR;
      4'd5: w_i_f3 = F3_AND;
      4'd6: begin w_i_f3 = F3_SLL;     w_i_imm = {F7_BASE, i_lfsr[23:19]}; end
      4'd7: begin w_i_f3 = F3_SRL_SRA; w_i_imm = {F7_BASE, i_lfsr[23:19]}; end
      4'd8: begin w_i_f3 = F3_SRL_SRA; w_i_imm = {F7_ALT, i_lfsr[23:19]}; end
      default: w_i_f3 = F3_ADD_SUB;
    endcase
  end

  always_comb begin
    o_instr = NOP_WORD;
    case (i_lfsr[1:0])
      2'd0: o_instr = {w_r_f7, w_rs2, w_rs1, w_r_f3, w_rd, OP_R};
      2'd1: o_instr = {w_i_imm, w_rs1, w_i_f3, w_rd, OP_I};
      2'd2: begin
        if (i_lfsr[2]) begin
          o_instr = {w_mem_imm[11:5], w_rs2, 5'd0, F3_WORD, w_mem_imm[4:0], OP_STORE};
        end else begin
          o_instr = {w_mem_imm, 5'd0, F3_WORD, w_rd, OP_LOAD};
        end
      end
      default: o_instr = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/inst_gen.sv
// Random instruction source: run FSM, 32-bit LFSR and handshake counter.
// Build with INST_GEN_MUL_EN to let the encoder emit MUL/MULH/MULHSU/MULHU.
module inst_gen
  import ridecore_inst_pkg::*;
#(
  parameter int unsigned NUM_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [NUM_W-1:0] num_insts,
  input  logic             inst_ready,
  output logic             inst_valid,
  output logic [31:0]      instruction,
  output logic [NUM_W-1:0] issued_count,
  output logic             done
);

  state_t           r_state, w_state_d;
  logic [31:0]      r_lfsr, w_lfsr_d;
  logic [31:0]      r_seed, w_seed_d;
  logic [NUM_W-1:0] r_num, w_num_d;
  logic [NUM_W-1:0] r_count, w_count_d, w_count_inc;
  logic [31:0]      w_encoded;

  assign w_count_inc = r_count + {{(NUM_W-1){1'b0}}, 1'b1};

  always_comb begin
    w_state_d = r_state;
    w_lfsr_d  = r_lfsr;
    w_seed_d  = r_seed;
    w_num_d   = r_num;
    w_count_d = r_count;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_seed_d  = seed;
          w_num_d   = num_insts;
          w_state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_lfsr_d  = (r_seed == 32'h0) ? LFSR_INIT : r_seed;
        w_count_d = '0;
        w_state_d = (r_num == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // Count guard keeps issued_count pinned at num_insts.
        if (inst_ready && (r_count != r_num)) begin
          w_lfsr_d  = lfsr_step(r_lfsr);
          w_count_d = w_count_inc;
          if (w_count_inc == r_num) w_state_d = ST_DONE;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_lfsr  <= LFSR_INIT;
      r_seed  <= 32'h0;
      r_num   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_d;
      r_lfsr  <= w_lfsr_d;
      r_seed  <= w_seed_d;
      r_num   <= w_num_d;
      r_count <= w_count_d;
    end
  end

  inst_encode u_encode (
    .i_lfsr  (r_lfsr),
    .o_instr (w_encoded)
  );

  assign inst_valid   = (r_state == ST_RUN);
  assign instruction  = inst_valid ? w_encoded : 32'h0;
  assign issued_count = r_count;
  assign done         = (r_state == ST_DONE);

endmodule

// File: tb/tb_inst_gen.sv
// Directed and constrained-random bench for inst_gen.
// Define INST_GEN_MUL_EN for both bench and RTL to cover the multiply ops.
module tb_inst_gen;

`ifdef INST_GEN_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] seed = 32'h0;
  logic [15:0] num_insts = 16'h0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [15:0] issued_count;
  logic        done;

  int total = 0;
  int bad = 0;

  inst_gen #(.NUM_W(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .seed         (seed),
    .num_insts    (num_insts),
    .inst_ready   (inst_ready),
    .inst_valid   (inst_valid),
    .instruction  (instruction),
    .issued_count (issued_count),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [31:0] s, input logic [15:0] n);
    start = 1'b1;
    seed = s;
    num_insts = n;
    cyc();
    start = 1'b0;
  endtask

  function automatic logic [31:0] lfsr_model(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [6:0] class_op(input logic [31:0] m);
    case (m[1:0])
      2'd0: return 7'b0110011;
      2'd1: return 7'b0010011;
      2'd2: return m[2] ? 7'b0100011 : 7'b0000011;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic bit legal(input logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    case (w[6:0])
      7'b0110011: begin
        if (w[11] || w[19] || w[24]) return 1'b0;
        if (f7 == 7'b0000000) return 1'b1;
        if (f7 == 7'b0100000) return (f3 == 3'b000) || (f3 == 3'b101);
        if (f7 == 7'b0000001) return MulEn && (f3 <= 3'b011);
        return 1'b0;
      end
      7'b0010011: begin
        if (w[11] || w[19]) return 1'b0;
        if (f3 == 3'b001) return f7 == 7'b0000000;
        if (f3 == 3'b101) return (f7 == 7'b0000000) || (f7 == 7'b0100000);
        return 1'b1;
      end
      7'b0000011: return (f3 == 3'b010) && (w[19:15] == 5'd0) && (w[31:30] == 2'b00) && !w[11];
      7'b0100011: return (f3 == 3'b010) && (w[19:15] == 5'd0) && (w[31:30] == 2'b00) && !w[24];
      default: return w == 32'h0000_007F;
    endcase
  endfunction

  // Index into ADD..AND, MUL..MULHU; 15 for anything unrecognised.
  function automatic int r_op_id(input logic [31:0] w);
    logic [9:0] k;
    k = {w[31:25], w[14:12]};
    case (k)
      10'b0000000_000: return 0;
      10'b0100000_000: return 1;
      10'b0000000_001: return 2;
      10'b0000000_010: return 3;
      10'b0000000_011: return 4;
      10'b0000000_100: return 5;
      10'b0000000_101: return 6;
      10'b0100000_101: return 7;
      10'b0000000_110: return 8;
      10'b0000000_111: return 9;
      10'b0000001_000: return 10;
      10'b0000001_001: return 11;
      10'b0000001_010: return 12;
      10'b0000001_011: return 13;
      default: return 15;
    endcase
  endfunction

  logic [31:0] s0_words [4];
  logic [31:0] s3_words [4];
  logic [31:0] model;
  logic [15:0] seen;
  int          mul_seen;
  int          model_cnt;

  initial begin
    s0_words = '{32'h0000_0013, 32'h0000_007F, 32'h0060_2003, 32'hC030_0013};
    s3_words = '{32'h0000_007F, 32'h0060_2003, 32'hC030_0013, 32'h0000_007F};

    // Reset values
    repeat (2) @(posedge clk);
    mid();
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_issued", {16'd0, issued_count}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Scenario 1: seed 0 loads LFSR=1, three words back to back
    inst_ready = 1'b1;
    start_run(32'h0, 16'd3);
    mid();
    chk("s1_load_valid", {31'd0, inst_valid}, 32'd0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("s1_valid", {31'd0, inst_valid}, 32'd1);
      chk("s1_instr", instruction, s0_words[i]);
      chk("s1_issued", {16'd0, issued_count}, i);
      cyc();
    end
    mid();
    chk("s1_done", {31'd0, done}, 32'd1);
    chk("s1_end_valid", {31'd0, inst_valid}, 32'd0);
    chk("s1_end_instr", instruction, 32'h0);
    chk("s1_end_issued", {16'd0, issued_count}, 32'd3);
    cyc();

    // Scenario 2: zero-length run goes LOAD -> DONE
    start_run(32'h0000_1234, 16'd0);
    mid();
    chk("s2_load_done", {31'd0, done}, 32'd0);
    chk("s2_load_valid", {31'd0, inst_valid}, 32'd0);
    cyc();
    mid();
    chk("s2_done", {31'd0, done}, 32'd1);
    chk("s2_valid", {31'd0, inst_valid}, 32'd0);
    chk("s2_issued", {16'd0, issued_count}, 32'd0);
    cyc();
    mid();
    chk("s2_hold_valid", {31'd0, inst_valid}, 32'd0);
    chk("s2_hold_done", {31'd0, done}, 32'd1);
    cyc();

    // R-ALU words: SUB x3,x5,x10 then OR x9,x2,x5
    start_run(32'h0005_2988, 16'd2);
    cyc();
    mid();
    chk("r_sub", instruction, 32'h40A2_81B3);
    cyc();
    mid();
    chk("r_or", instruction, 32'h0051_64B3);
    cyc();
    mid();
    chk("r_done", {31'd0, done}, 32'd1);
    cyc();

    // Scenarios 3 and 6: backpressure, starts ignored in LOAD and RUN
    inst_ready = 1'b0;
    start_run(32'h0, 16'd5);
    mid();
    chk("s3_load_valid", {31'd0, inst_valid}, 32'd0);
    start = 1'b1;
    seed = 32'h0000_FFFF;
    num_insts = 16'd9;
    cyc();
    start = 1'b0;
    mid();
    chk("s3_first_instr", instruction, 32'h0000_0013);
    chk("s3_first_issued", {16'd0, issued_count}, 32'd0);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("s3_stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("s3_stall_instr", instruction, 32'h0000_007F);
      chk("s3_stall_issued", {16'd0, issued_count}, 32'd1);
      start = (k == 2);
      seed = 32'h0000_0055;
      num_insts = 16'd2;
      cyc();
    end
    start = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("s3_instr", instruction, s3_words[i]);
      chk("s3_issued", {16'd0, issued_count}, i + 1);
      cyc();
    end
    mid();
    chk("s3_done", {31'd0, done}, 32'd1);
    chk("s3_issued_end", {16'd0, issued_count}, 32'd5);
    cyc();

    // Scenario 5: reset after 4 handshakes, then replay the same seed
    start_run(32'h0, 16'd10);
    cyc();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("s5_pre_instr", instruction, s0_words[i]);
      cyc();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("s5_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("s5_rst_instr", instruction, 32'h0);
    chk("s5_rst_issued", {16'd0, issued_count}, 32'd0);
    chk("s5_rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) cyc();
    mid();
    chk("s5_idle_valid", {31'd0, inst_valid}, 32'd0);
    chk("s5_idle_done", {31'd0, done}, 32'd0);
    start_run(32'h0, 16'd10);
    cyc();
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("s5_replay_instr", instruction, s0_words[i]);
      cyc();
    end
    for (int c = 0; c < 20; c++) begin
      mid();
      if (done) break;
      cyc();
    end
    chk("s5_done", {31'd0, done}, 32'd1);
    chk("s5_issued", {16'd0, issued_count}, 32'd10);
    cyc();

    // Scenario 4: 10000 words, random backpressure, LFSR model tracks class
    model = 32'h1357_9BDF;
    model_cnt = 0;
    seen = 16'h0;
    mul_seen = 0;
    start_run(model, 16'd10000);
    for (int c = 0; c < 60000; c++) begin
      mid();
      if (done) break;
      if (inst_valid) begin
        chk("s4_legal", {31'd0, legal(instruction)}, 32'd1);
        chk("s4_class", {25'd0, instruction[6:0]}, {25'd0, class_op(model)});
        chk("s4_issued", {16'd0, issued_count}, model_cnt);
        if (instruction[6:0] == 7'b0110011) begin
          seen[r_op_id(instruction)] = 1'b1;
          if (instruction[31:25] == 7'b0000001) mul_seen++;
        end
        if (inst_ready) begin
          model = lfsr_model(model);
          model_cnt++;
        end
      end
      cyc();
      inst_ready = ($urandom_range(0, 3) != 0);
    end
    chk("s4_done", {31'd0, done}, 32'd1);
    chk("s4_issued_end", {16'd0, issued_count}, 32'd10000);
    chk("s4_no_bad_rop", {31'd0, seen[15]}, 32'd0);
`ifdef INST_GEN_MUL_EN
    chk("s4_all_r_ops", {18'd0, seen[13:0]}, 32'h0000_3FFF);
`else
    chk("s4_base_r_ops", {22'd0, seen[9:0]}, 32'h0000_03FF);
    chk("s4_no_mul", mul_seen, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_gen.md
INST_GEN -- requirements
Module: inst_gen

Interface
REQ-001 Parameter NUM_W, default 16: width of the instruction-count ports.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse that launches a generation run; sampled only in IDLE and DONE.
REQ-005 seed  input  32  LFSR seed, captured on an accepted start.
REQ-006 num_insts  input  NUM_W  number of instructions in a run, captured on an accepted start.
REQ-007 inst_ready  input  1  consumer (fetch stub) accepts the instruction this cycle.
REQ-008 inst_valid  output  1  instruction holds a legal instruction.
REQ-009 instruction  output  32  generated RV32 instruction word.
REQ-010 issued_count  output  NUM_W  instructions accepted so far in the current run.
REQ-011 done  output  1  run complete; held high until the next accepted start.

Function
REQ-012 States: IDLE, LOAD, RUN, DONE.
- IDLE to LOAD on start.
- LOAD to RUN after one cycle; to DONE if the captured num_insts is 0.
- RUN to DONE on the handshake that makes issued_count equal num_insts.
- DONE to LOAD on start.
REQ-013 LOAD sets lfsr to seed, or to 32'h0000_0001 if seed is 0, and clears issued_count.
REQ-014 LFSR: 32-bit Galois, tap mask 32'h8020_0003, shifting right.
REQ-015 LFSR advance and issued_count increment happen exactly once per handshake (inst_valid and inst_ready both high in the same cycle).
REQ-016 inst_valid is high only in RUN; instruction is 32'h0 whenever inst_valid is low.
REQ-017 instruction is a combinational encode of the current LFSR state, so it stays stable under backpressure. Latency from LOAD to first valid is 1 cycle.
REQ-018 Class selection from lfsr[1:0]: 0 = R-ALU, 1 = I-ALU, 2 = LW/SW (lfsr[2] picks SW), 3 = NOP.
REQ-019 Register fields:
- rd, rs1, rs2 are taken from LFSR bits with bit 4 forced to 0, so all lie in 0..15.
- LW and SW use rs1 = 0 and imm[11:10] = 2'b00.
REQ-020 R-ALU op index:
- idx = lfsr[6:3]; if idx >= N_R, subtract N_R.
- Ops in order: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHSU, MULHU.
- Opcode 7'b0110011, with standard funct3/funct7.
REQ-021 I-ALU op index:
- idx = lfsr[6:3]; if idx >= 9, subtract 9.
- Ops in order: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- Opcode 7'b0010011.
- Shifts carry funct7 0000000 (0100000 for SRAI) and shamt from the LFSR.
- Other I ops carry a 12-bit immediate from the LFSR.
REQ-022 NOP is exactly 32'h0000_007F.
REQ-023 Every emitted word satisfies the team's allowed-instruction property (R/I ALU, restricted LW/SW, or opcode 7'b1111111).
REQ-024 A start while in RUN or LOAD is ignored.
REQ-025 inst_ready while inst_valid is low has no effect.
REQ-026 issued_count saturates at num_insts and never wraps.

Reset
REQ-027 While reset_n is low:
- state = IDLE, lfsr = 32'h0000_0001, issued_count = 0.
- inst_valid = 0, instruction = 0, done = 0.
REQ-028 Reset asserted mid-run aborts the run immediately with no further handshakes. After release the block waits in IDLE for start.

Configuration
REQ-029 Macro INST_GEN_MUL_EN controls the multiply ops.
- Defined: N_R = 14 and MUL, MULH, MULHSU, MULHU can be emitted.
- Undefined: N_R = 10 and funct7 7'b0000001 is never emitted.

Structure
REQ-030 Package ridecore_inst_pkg holds:
- opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_NOP);
- funct3/funct7 constants;
- the FSM state enum;
- the LFSR tap mask;
- the NOP word.
REQ-031 Sub-module inst_encode (combinational: lfsr in, 32-bit instruction out) holds the encoding. inst_gen holds the FSM, LFSR and counter.

Verification
REQ-032 Scenario 1: seed = 0, num_insts = 3, inst_ready tied high.
- LFSR loads 1.
- Exactly 3 valid cycles.
- done rises the cycle after the third handshake, with issued_count = 3.
REQ-033 Scenario 2: num_insts = 0, start pulsed.
- LOAD, then DONE; inst_valid never rises; done = 1.
REQ-034 Scenario 3: inst_ready low for 5 cycles during RUN.
- instruction and issued_count stay constant.
- The LFSR does not advance.
REQ-035 Scenario 4: 10000 random instructions with random inst_ready, built without INST_GEN_MUL_EN.
- Every word passes the allowed-instruction checker.
- No funct7 = 0000001 appears.
- Rebuilt with the macro, all 14 R ops are observed.
REQ-036 Scenario 5: reset_n pulled low after 4 handshakes of a 10-instruction run.
- All outputs return to reset values.
- A later start with the same seed reproduces the identical instruction sequence.
REQ-037 Scenario 6: start pulsed during RUN.
- The run continues and ends at the original num_insts.
